// File: rtl/draw_cmd_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : draw_cmd_queue_if
//  Description : Bundles the CPU register-write port, the status outputs and
//                the draw-unit command/handshake signals of draw_cmd_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface draw_cmd_queue_if;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [31:0]  status;
    logic         cmd_full;
    logic [7:0]   command;
    logic [255:0] data;
    logic         commit;
    logic         ack;
    logic         done;

    // The queue itself: consumes CPU writes and draw-unit handshakes.
    modport slave (
        input  wr_en, wr_addr, wr_data, ack, done,
        output status, cmd_full, command, data, commit
    );

    // The environment: CPU plus draw unit.
    modport master (
        output wr_en, wr_addr, wr_data, ack, done,
        input  status, cmd_full, command, data, commit
    );
endinterface
`default_nettype wire

// File: rtl/draw_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : draw_cmd_queue
//  Description : Captures CPU register writes into an operand staging area,
//                pushes 8-bit commands with 256-bit operand blocks into a
//                small FIFO and issues them one at a time to the draw unit,
//                gated by ack and paced by done.
//  Revision    : 1.0 - initial release
// ============================================================================
module draw_cmd_queue #(
    parameter int DEPTH_BITS = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    draw_cmd_queue_if.slave   bus
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] C_FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             stage_q [8];
    logic [263:0]            mem_q   [DEPTH];
    logic [DEPTH_BITS-1:0]   head_q, tail_q;
    logic [DEPTH_BITS:0]     count_q;
    logic                    overflow_q;
    logic [7:0]              command_q;
    logic [255:0]            data_q;
    logic                    commit_q;

    logic [255:0]            staged_w;
    logic                    stage_we_w;
    logic                    push_req_w;
    logic                    ctrl_we_w;
    logic                    full_w;
    logic                    empty_w;
    logic                    push_w;
    logic                    issue_w;

    // Operand block as seen by a push: slot i occupies bits [32i+31:32i].
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_stage
            assign staged_w[32*gi +: 32] = stage_q[gi];
        end
    endgenerate

    assign stage_we_w = bus.wr_en && (bus.wr_addr[3] == 1'b0);
    assign push_req_w = bus.wr_en && (bus.wr_addr == 4'd8);
    assign ctrl_we_w  = bus.wr_en && (bus.wr_addr == 4'd9);

    // Fullness is judged on the registered count, so a pop in the same
    // cycle never makes room for a push.
    assign full_w  = (count_q == C_FULL_COUNT);
    assign empty_w = (count_q == '0);
    assign push_w  = push_req_w && !full_w;

    // Staging registers survive pushes so an operand block can be reused.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                stage_q[i] <= '0;
            end
        end else if (stage_we_w) begin
            stage_q[bus.wr_addr[2:0]] <= bus.wr_data;
        end
    end

    // FIFO storage: command byte on top of the operand block.
    always_ff @(posedge clk_i) begin
        if (push_w) begin
            mem_q[tail_q] <= {bus.wr_data[7:0], staged_w};
        end
    end

    // Head/tail pointers wrap naturally; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_w) begin
                tail_q <= tail_q + 1'b1;
            end
            if (issue_w) begin
                head_q <= head_q + 1'b1;
            end
            case ({push_w, issue_w})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow: set by a dropped push, cleared by control bit 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (push_req_w && full_w) begin
            overflow_q <= 1'b1;
        end else if (ctrl_we_w && bus.wr_data[0]) begin
            overflow_q <= 1'b0;
        end
    end

    // Dispatcher state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dispatcher next state: issue from IDLE when ready, wait for done.
    always_comb begin
        state_d = state_q;
        issue_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_w && bus.ack) begin
                    issue_w = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue registers: command/data hold until the next issue; commit pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            command_q <= '0;
            data_q    <= '0;
            commit_q  <= 1'b0;
        end else begin
            commit_q <= issue_w;
            if (issue_w) begin
                {command_q, data_q} <= mem_q[head_q];
            end
        end
    end

    assign bus.command  = command_q;
    assign bus.data     = data_q;
    assign bus.commit   = commit_q;
    assign bus.cmd_full = full_w;
    assign bus.status   = {20'd0, overflow_q, (state_q == ST_WAIT),
                           full_w, empty_w, 8'(count_q)};

endmodule
`default_nettype wire

// File: tb/tb_draw_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_draw_cmd_queue
//  Description : Self-checking bench for draw_cmd_queue with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_cmd_queue;

    localparam int DB    = 2;
    localparam int DEPTH = 1 << DB;

    typedef struct packed {
        logic [7:0]   c;
        logic [255:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    draw_cmd_queue_if bus();

    draw_cmd_queue #(.DEPTH_BITS(DB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference model state
    logic [31:0]  m_stage [8];
    ent_t         m_q [$];
    logic         m_ovf;
    logic         m_busy;
    logic         m_commit;
    logic [7:0]   m_cmd;
    logic [255:0] m_data;

    function automatic logic [255:0] staged();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = m_stage[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = '0;
        s[7:0]  = 8'(m_q.size());
        s[8]    = (m_q.size() == 0);
        s[9]    = (m_q.size() == DEPTH);
        s[10]   = m_busy;
        s[11]   = m_ovf;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_stage[i] = '0;
        m_q.delete();
        m_ovf    = 1'b0;
        m_busy   = 1'b0;
        m_commit = 1'b0;
        m_cmd    = '0;
        m_data   = '0;
    endtask

    // One rising edge of the specified behaviour.
    task automatic model_edge();
        ent_t e;
        bit   full;
        bit   pop;
        if (rst) begin
            model_reset();
            return;
        end
        full     = (m_q.size() == DEPTH);
        pop      = !m_busy && (m_q.size() != 0) && bus.ack;
        m_commit = 1'b0;
        if (m_busy && bus.done) m_busy = 1'b0;
        if (pop) begin
            m_cmd    = m_q[0].c;
            m_data   = m_q[0].d;
            void'(m_q.pop_front());
            m_busy   = 1'b1;
            m_commit = 1'b1;
        end
        if (bus.wr_en) begin
            if (bus.wr_addr < 4'd8) begin
                m_stage[bus.wr_addr[2:0]] = bus.wr_data;
            end else if (bus.wr_addr == 4'd8) begin
                if (full) begin
                    m_ovf = 1'b1;
                end else begin
                    e.c = bus.wr_data[7:0];
                    e.d = staged();
                    m_q.push_back(e);
                end
            end else if (bus.wr_addr == 4'd9 && bus.wr_data[0]) begin
                m_ovf = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("status",   256'(bus.status),   256'(exp_status()));
        chk("cmd_full", 256'(bus.cmd_full), 256'(m_q.size() == DEPTH));
        chk("commit",   256'(bus.commit),   256'(m_commit));
        chk("command",  256'(bus.command),  256'(m_cmd));
        chk("data",     bus.data,           m_data);
    endtask

    // Advance one clock; model follows the edge, outputs compared on negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.ack     = 1'b0;
        bus.done    = 1'b0;
        model_reset();
        repeat (3) step();
        chk("reset_status", 256'(bus.status), 256'(32'h100));
        rst = 1'b0;
        step();

        // Single command
        bus.ack = 1'b1;
        for (int i = 0; i < 8; i++) wr(4'(i), 32'h11111111 * (i + 1));
        wr(4'd8, 32'h05);
        step();
        chk("single_commit",  256'(bus.commit),        256'(1'b1));
        chk("single_command", 256'(bus.command),       256'(8'h05));
        chk("single_d_lo",    256'(bus.data[31:0]),    256'(32'h11111111));
        chk("single_d_hi",    256'(bus.data[255:224]), 256'(32'h88888888));
        chk("single_status",  256'(bus.status),        256'(32'h500));
        step();
        chk("single_pulse",   256'(bus.commit),        256'(1'b0));
        bus.ack = 1'b0;
        pulse_done();

        // Fill and overflow
        for (int i = 1; i <= 5; i++) wr(4'd8, 32'(i));
        chk("fill_status",   256'(bus.status),   256'(32'hA04));
        chk("fill_cmd_full", 256'(bus.cmd_full), 256'(1'b1));
        wr(4'd9, 32'h1);
        chk("ovf_clear",     256'(bus.status),   256'(32'h204));

        // Push while full during an issue: dropped, count drops to 3
        bus.ack = 1'b1;
        wr(4'd8, 32'h77);
        bus.ack = 1'b0;
        chk("full_pushpop",  256'(bus.status),   256'(32'hC03));
        chk("full_pp_cmd",   256'(bus.command),  256'(8'h01));

        // Asynchronous reset mid-WAIT with entries queued
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_status",  256'(bus.status),  256'(32'h100));
        chk("arst_commit",  256'(bus.commit),  256'(1'b0));
        chk("arst_command", 256'(bus.command), 256'(8'h00));
        @(negedge clk);
        repeat (2) step();
        rst = 1'b0;
        pulse_done();
        bus.ack = 1'b1;
        step();
        chk("arst_no_issue", 256'(bus.commit), 256'(1'b0));
        bus.ack = 1'b0;

        // Push concurrent with an issue at count 2
        wr(4'd8, 32'h21);
        wr(4'd8, 32'h22);
        bus.ack = 1'b1;
        wr(4'd8, 32'h23);
        bus.ack = 1'b0;
        chk("pp2_status", 256'(bus.status), 256'(32'h402));
        chk("pp2_commit", 256'(bus.commit), 256'(1'b1));
        pulse_done();

        // Ack gating and stray done
        repeat (10) step();
        chk("gate_no_commit", 256'(bus.commit), 256'(1'b0));
        pulse_done();
        bus.ack = 1'b1;
        step();
        chk("gate_commit",  256'(bus.commit),  256'(1'b1));
        chk("gate_command", 256'(bus.command), 256'(8'h22));
        bus.ack = 1'b0;
        pulse_done();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            bus.wr_en   = ($urandom_range(0, 1) == 1);
            bus.wr_addr = ($urandom_range(0, 2) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            bus.wr_data = $urandom;
            bus.ack     = ($urandom_range(0, 9) < 6);
            bus.done    = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            step();
        end
        rst       = 1'b0;
        bus.wr_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/draw_cmd_queue.md
# draw_cmd_queue

Front end of the graphics pipeline: captures CPU register writes, assembles 8-bit draw commands with 256-bit operand blocks, buffers them in a small FIFO, and issues them one at a time to the draw unit. It sits between the CPU's memory-mapped graphics window and the draw unit's `command`/`data`/`commit` inputs. Issue is gated by the draw unit's `ack` (ready) and paced by its `done` pulse.

## Interface
- `DEPTH_BITS`, default 2: log2 of FIFO depth; default depth is 4 entries.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  CPU register write strobe, one cycle per write.
- `wr_addr`  in  4  register select:
  - 0–7: operand word slot.
  - 8: command / push.
  - 9: control.
  - 10–15: ignored.
- `wr_data`  in  32  CPU write data.
- `status`  out  32  status word; layout under Operation.
- `cmd_full`  out  1  FIFO full; CPU software must poll this before pushing.
- `command`  out  8  command to the draw unit.
- `data`  out  256  operand block to the draw unit.
- `commit`  out  1  one-cycle issue strobe to the draw unit.
- `ack`  in  1  draw unit ready; high means it can accept a command.
- `done`  in  1  one-cycle pulse from the draw unit when the current command completes.

## Operation
- **Staging.** Eight 32-bit registers `stage[0..7]`.
  - A write to address `i` (0–7) loads `stage[i]`.
  - The staged block is `data[32i+31:32i] = stage[i]`.
  - Staging is not cleared by a push, so one operand block can be reused across commands.
- **Push (address 8).**
  - If `cmd_full`=0, write entry `{wr_data[7:0], staged 256-bit block}` at the FIFO tail.
  - If `cmd_full`=1, drop the write and set sticky `overflow`.
  - Full is evaluated on the registered count before any same-cycle pop. A push while full is therefore dropped even if a pop occurs in the same cycle.
- **Control (address 9).** `wr_data[0]`=1 clears `overflow`. Other bits are ignored.
- **Write ordering.** A staging write and a push in consecutive cycles behave as expected: the push captures the newly written word.
- **FIFO.**
  - Depth is 2^`DEPTH_BITS`; head and tail pointers wrap modulo depth.
  - `count` is `DEPTH_BITS`+1 bits wide, range 0..depth.
  - Simultaneous push (when not full) and pop leaves `count` unchanged.
- **Dispatcher FSM**, two states:
  - **IDLE:** if FIFO not empty and `ack`=1, register the head entry onto `command`/`data`, assert `commit` for the next cycle, pop, and go to WAIT.
  - **WAIT:** hold `command`/`data` stable. On `done`=1 go to IDLE.
  - `done` in IDLE is ignored.
  - `ack` is only sampled in IDLE.
- **Output stability.** `command`/`data` retain the last issued value until the next issue.
- **`status` layout** (combinational from registers):
  - [7:0] `count`, zero-extended.
  - [8] empty.
  - [9] full.
  - [10] busy (state is WAIT).
  - [11] `overflow`.
  - [31:12] zero.
- **`cmd_full`** equals `status[9]`.

## Timing
- **Reset** (asynchronous, any time, including mid-command). On reset:
  - State goes to IDLE.
  - `commit`=0, `command`=0, `data`=0.
  - All `stage`=0, pointers=0, `count`=0, `overflow`=0.
  - `status`=0x100 (empty only), `cmd_full`=0.
  - A command outstanding at the draw unit is abandoned; its later `done` is ignored.
- **Latency.**
  - Push sampled at edge E; the entry is counted from E.
  - If IDLE with `ack`=1, `commit` is high for exactly the cycle after edge E+1, with `command`/`data` valid in that same cycle.
- **Pulse width.** `commit` never exceeds one cycle. Consecutive commits are separated by at least one cycle, since the FSM passes through WAIT.
- **Return from WAIT.** `done` sampled at edge D moves the FSM to IDLE. The next commit can occur at the earliest in the cycle after edge D+1.
- **Wait on ready.** With entries queued and `ack`=0 in IDLE, the FSM holds without issuing or popping.

## Test plan
- **Reset.** Assert `rst` mid-WAIT with 2 entries queued → `status`=0x100, `commit`=0, `command`=0 immediately; a later `done` pulse causes no issue.
- **Single command.** Write 0x11111111..0x88888888 to slots 0–7, then 0x05 to address 8, with `ack`=1 → one-cycle `commit` two edges later, `command`=0x05, `data[31:0]`=0x11111111, `data[255:224]`=0x88888888, `status[10]`=1.
- **Fill and overflow.** With `ack`=0, push 5 commands (DEPTH_BITS=2) → `count`=4, `cmd_full`=1, `status[11]`=1, 5th dropped. Write 1 to address 9 → `status[11]`=0.
- **Ordering and wrap.** Push 0x01..0x04, drain with `done` pulses, push 0x05..0x07, drain → commits issue in order 0x01..0x07, pointers wrap, `count` ends at 0.
- **Simultaneous push/pop.** With `count`=2, push in the same cycle as an issue → `count` stays 2. Repeat with `count`=4 → push dropped, `count` becomes 3, `overflow` set.
- **Ack gating and stray done.** Queue 1 entry with `ack`=0 for 10 cycles → no `commit`. Pulse `done` in IDLE → no effect. Raise `ack` → `commit` on the next cycle.
